// File: rtl/hc_sequencer.sv
// ============================================================================
// Module   : hc_sequencer
// Brief    : Control sequencer for a table-based stream cipher core
//            (key/IV load, table expansion, mixing, per-word keystream gen).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hc_sequencer #(
  parameter int DP_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        next,
  output logic        ready,
  output logic        ks_valid,
  output logic        dp_load,
  output logic        dp_expand,
  output logic        dp_step,
  output logic        dp_init_mode,
  output logic [10:0] dp_idx
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_EXPAND = 3'd2;
  localparam logic [2:0] C_MIX    = 3'd3;
  localparam logic [2:0] C_READY  = 3'd4;
  localparam logic [2:0] C_GEN    = 3'd5;
  localparam logic [2:0] C_WAIT   = 3'd6;

  localparam logic [10:0] C_EXP_FIRST = 11'd16;
  localparam logic [10:0] C_EXP_LAST  = 11'd1279;
  localparam logic [10:0] C_MIX_LAST  = 11'd1023;
  localparam logic [10:0] C_WAIT_LAST = 11'(DP_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [9:0]  ks_ctr_q, ks_ctr_d;
  logic        ks_valid_q, ks_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= C_IDLE;
      cnt_q      <= 11'd0;
      ks_ctr_q   <= 10'd0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ks_ctr_q   <= ks_ctr_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  // init has priority over next in READY; both are ignored while busy.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ks_ctr_d   = ks_ctr_q;
    ks_valid_d = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (init) begin
          state_d = C_LOAD;
          cnt_d   = 11'd0;
        end
      end
      C_LOAD: begin
        state_d = C_EXPAND;
        cnt_d   = C_EXP_FIRST;
      end
      C_EXPAND: begin
        if (cnt_q == C_EXP_LAST) begin
          state_d = C_MIX;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      C_MIX: begin
        if (cnt_q == C_MIX_LAST) begin
          state_d  = C_READY;
          cnt_d    = 11'd0;
          ks_ctr_d = 10'd0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      C_READY: begin
        if (init) begin
          state_d = C_LOAD;
          cnt_d   = 11'd0;
        end else if (next) begin
          state_d = C_GEN;
        end
      end
      C_GEN: begin
        ks_ctr_d = ks_ctr_q + 10'd1;
        if (DP_LAT == 1) begin
          state_d    = C_READY;
          ks_valid_d = 1'b1;
        end else begin
          state_d = C_WAIT;
          cnt_d   = 11'd1;
        end
      end
      C_WAIT: begin
        if (cnt_q == C_WAIT_LAST) begin
          state_d    = C_READY;
          cnt_d      = 11'd0;
          ks_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = 11'd0;
      end
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    ks_valid     = ks_valid_q;
    dp_load      = 1'b0;
    dp_expand    = 1'b0;
    dp_step      = 1'b0;
    dp_init_mode = 1'b0;
    dp_idx       = 11'd0;
    case (state_q)
      C_LOAD: begin
        dp_load = 1'b1;
      end
      C_EXPAND: begin
        dp_expand = 1'b1;
        dp_idx    = cnt_q;
      end
      C_MIX: begin
        dp_step      = 1'b1;
        dp_init_mode = 1'b1;
        dp_idx       = {1'b0, cnt_q[9:0]};
      end
      C_READY: begin
        ready = 1'b1;
      end
      C_GEN: begin
        dp_step = 1'b1;
        dp_idx  = {1'b0, ks_ctr_q};
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hc_sequencer.sv
// ============================================================================
// Module   : tb_hc_sequencer
// Brief    : Scoreboard bench for hc_sequencer, DP_LAT=1 and DP_LAT=3 instances.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hc_sequencer;

  typedef struct {
    logic [16:0] v;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v  [2];
  logic        init_v [2];
  logic        next_v [2];
  logic        ready_v[2];
  logic        ksv_v  [2];
  logic        load_v [2];
  logic        exp_v  [2];
  logic        step_v [2];
  logic        im_v   [2];
  logic [10:0] idx_v  [2];

  hc_sequencer #(.DP_LAT(1)) u_lat1 (
    .clk(clk), .reset(rst_v[0]), .init(init_v[0]), .next(next_v[0]),
    .ready(ready_v[0]), .ks_valid(ksv_v[0]), .dp_load(load_v[0]),
    .dp_expand(exp_v[0]), .dp_step(step_v[0]), .dp_init_mode(im_v[0]),
    .dp_idx(idx_v[0])
  );

  hc_sequencer #(.DP_LAT(3)) u_lat3 (
    .clk(clk), .reset(rst_v[1]), .init(init_v[1]), .next(next_v[1]),
    .ready(ready_v[1]), .ks_valid(ksv_v[1]), .dp_load(load_v[1]),
    .dp_expand(exp_v[1]), .dp_step(step_v[1]), .dp_init_mode(im_v[1]),
    .dp_idx(idx_v[1])
  );

  ev_t  q0[$];
  ev_t  q1[$];
  int   total = 0;
  int   bad   = 0;
  int   ks_exp[2];
  bit   done  = 1'b0;
  logic rst_smp [2] = '{1'b0, 1'b0};
  logic rdy_prev[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    rst_smp[0] <= rst_v[0];
    rst_smp[1] <= rst_v[1];
  end

  function automatic logic [16:0] mk(input logic l, input logic x, input logic s,
                                     input logic im, input logic k, input logic r,
                                     input logic [10:0] idx);
    return {l, x, s, im, k, r, idx};
  endfunction

  function automatic void pushev(input int d, input logic [16:0] v, input int c);
    ev_t e;
    e.v   = v;
    e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void flush(input int d, input int from);
    if (d == 0) begin
      while (q0.size() > 0 && q0[q0.size()-1].cyc >= from) q0.pop_back();
    end else begin
      while (q1.size() > 0 && q1[q1.size()-1].cyc >= from) q1.pop_back();
    end
  endfunction

  // Observation cycle c = the period right after rising edge c.
  function automatic void push_setup(input int d, input int n);
    pushev(d, mk(1, 0, 0, 0, 0, 0, 11'd0), n);
    for (int k = 0; k < 1264; k++) pushev(d, mk(0, 1, 0, 0, 0, 0, 11'(16 + k)), n + 1 + k);
    for (int k = 0; k < 1024; k++) pushev(d, mk(0, 0, 1, 1, 0, 0, 11'(k)), n + 1265 + k);
    pushev(d, mk(0, 0, 0, 0, 0, 1, 11'd0), n + 2289);
    ks_exp[d] = 0;
  endfunction

  // Monitor: every cycle with activity pops one expected event.
  always @(negedge clk) begin : mon
    logic [16:0] got;
    ev_t         e;
    bit          have;
    bit          evt;
    for (int d = 0; d < 2; d++) begin
      got = {load_v[d], exp_v[d], step_v[d], im_v[d], ksv_v[d], ready_v[d], idx_v[d]};
      if (rst_smp[d]) begin
        total++;
        if (got !== 17'd0) begin
          bad++;
          $display("FAIL reset_outputs dut%0d cyc=%0d got=%h want=0", d, cyc, got);
        end
      end
      evt = load_v[d] | exp_v[d] | step_v[d] | ksv_v[d] | (ready_v[d] & ~rdy_prev[d]);
      if (evt) begin
        total++;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1'b1;
        end
        if (!have) begin
          bad++;
          $display("FAIL unexpected_event dut%0d cyc=%0d got=%h want=none", d, cyc, got);
        end else if (got !== e.v || cyc != e.cyc) begin
          bad++;
          $display("FAIL event dut%0d got=%h@%0d want=%h@%0d", d, got, cyc, e.v, e.cyc);
        end
      end
      rdy_prev[d] = ready_v[d];
    end
  end

  task automatic go_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic pulse(input int d, input int e, input bit pi, input bit pn, input bit pr);
    go_edge(e);
    if (pr) begin
      flush(d, e);
      ks_exp[d] = 0;
      rst_v[d]  = 1'b1;
    end
    init_v[d] = pi;
    next_v[d] = pn;
    @(negedge clk);
    init_v[d] = 1'b0;
    next_v[d] = 1'b0;
    rst_v[d]  = 1'b0;
  endtask

  task automatic do_init(input int d, input int e, output int rdy);
    push_setup(d, e);
    pulse(d, e, 1'b1, 1'b0, 1'b0);
    rdy = e + 2290;
  endtask

  task automatic do_next(input int d, input int e, input int lat);
    pushev(d, mk(0, 0, 1, 0, 0, 0, 11'(ks_exp[d])), e);
    pushev(d, mk(0, 0, 0, 0, 1, 1, 11'd0), e + lat);
    ks_exp[d] = (ks_exp[d] + 1) % 1024;
    pulse(d, e, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic run(input int d);
    int lat;
    int b;
    int n;
    int r;
    int m;
    int rr;
    lat = (d == 0) ? 1 : 3;
    b   = cyc;
    go_edge(b + 3);
    rst_v[d] = 1'b0;
    pulse(d, b + 6, 1'b0, 1'b1, 1'b0);         // next in IDLE: ignored
    n = b + 8;
    do_init(d, n, r);
    pulse(d, n + 100, 1'b0, 1'b1, 1'b0);       // next in EXPAND: ignored
    m = r;
    for (int i = 0; i < 1025; i++) begin
      do_next(d, m, lat);
      if (d == 1 && i == 5) pulse(d, m + 2, 1'b1, 1'b0, 1'b0);  // init in WAIT: ignored
      m += 1 + lat;
    end
    n = m + 2;                                 // init+next together: rekey wins
    push_setup(d, n);
    pulse(d, n, 1'b1, 1'b1, 1'b0);
    r = n + 2290;
    do_next(d, r + 3, lat);
    m = r + 3 + 1 + lat;
    if (d == 0) begin
      pulse(d, m + 2, 1'b0, 1'b1, 1'b1);       // reset beats next in READY
    end else begin
      do_next(d, m + 2, lat);
      pulse(d, m + 4, 1'b0, 1'b0, 1'b1);       // reset in WAIT drops ks_valid
    end
    n = m + 10;
    do_init(d, n, r);
    rr = n + 1766;                             // edge ending MIX step 500
    pulse(d, rr, 1'b0, 1'b0, 1'b1);
    pulse(d, rr + 2, 1'b0, 1'b1, 1'b0);
    pulse(d, rr + 10, 1'b0, 1'b1, 1'b0);
    n = rr + 20;
    do_init(d, n, r);
    do_next(d, r, lat);
    go_edge(r + lat + 6);
  endtask

  initial begin
    rst_v[0] = 1'b1;  rst_v[1] = 1'b1;
    init_v[0] = 1'b0; init_v[1] = 1'b0;
    next_v[0] = 1'b0; next_v[1] = 1'b0;
    ks_exp[0] = 0;    ks_exp[1] = 0;
    @(negedge clk);
    run(0);
    run(1);
    repeat (10) @(negedge clk);
    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL leftover dut0 got=%0d pending want=0", q0.size());
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL leftover dut1 got=%0d pending want=0", q1.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL watchdog got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule

`default_nettype wire

// File: doc/hc_sequencer.md
HC_SEQUENCER -- requirements
Module: hc_sequencer

Interface
REQ-001 Parameter: DP_LAT, default 1, datapath cycles from dp_step to keystream word available (legal 1..7).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 init  input  1  start key/IV setup; single-cycle pulse.
REQ-005 next  input  1  request one keystream word; single-cycle pulse.
REQ-006 ready  output  1  setup complete, idle, next accepted.
REQ-007 ks_valid  output  1  one-cycle strobe, keystream word valid at datapath.
REQ-008 dp_load  output  1  datapath loads key/IV into W[0..15].
REQ-009 dp_expand  output  1  datapath computes W[dp_idx].
REQ-010 dp_step  output  1  datapath performs one P/Q update step.
REQ-011 dp_init_mode  output  1  step result fed back into table, not output.
REQ-012 dp_idx  output  11  expansion index (EXPAND) or step index j, bit 9 = table select Q (MIX/GEN).

Function
REQ-013 States: IDLE, LOAD, EXPAND, MIX, READY, GEN, WAIT; one-hot or binary at implementer's choice.
REQ-014 IDLE: all dp_* low, ready low; init -> LOAD; next ignored.
REQ-015 LOAD: exactly 1 cycle, dp_load=1, dp_idx=0; -> EXPAND with counter=16.
REQ-016 EXPAND: dp_expand=1, dp_idx=counter, counter increments 16..1279 (1264 cycles); after 1279 -> MIX with counter=0.
REQ-017 MIX: dp_step=1, dp_init_mode=1, dp_idx={1'b0,counter[9:0]}, counter 0..1023 (1024 cycles); after 1023 -> READY, keystream counter cleared to 0.
REQ-018 READY: ready=1, dp_* low; next -> GEN; init -> LOAD (rekey); init and next same cycle: init wins, next dropped.
REQ-019 GEN: exactly 1 cycle, dp_step=1, dp_init_mode=0, dp_idx={1'b0,ks_ctr}; ks_ctr (10 bit) increments, wraps 1023->0.
REQ-020 GEN -> WAIT if DP_LAT>1, holding DP_LAT-1 cycles; GEN/WAIT end -> READY with ks_valid=1 that cycle.
REQ-021 ks_valid high exactly one cycle per accepted next, DP_LAT cycles after GEN cycle; ready also high that cycle, so back-to-back next accepted.
REQ-022 init or next during LOAD/EXPAND/MIX/GEN/WAIT ignored; no queuing.
REQ-023 dp_load, dp_expand, dp_step mutually exclusive every cycle.
REQ-024 Outputs registered or decoded from state/counter only; no combinational path from init/next to any output.
REQ-025 Counter 11 bits; no value outside stated ranges reachable.

Reset
REQ-026 reset=1 at a rising edge -> next cycle: state IDLE, counter=0, ks_ctr=0, all outputs 0, regardless of prior state.
REQ-027 reset overrides init/next sampled same edge.
REQ-028 reset mid-EXPAND/MIX/WAIT aborts sequence; no ks_valid emitted afterwards for the aborted request.

Verification
REQ-029 init at edge N from IDLE -> dp_load cycle N+1; dp_expand cycles N+2..N+1265 (idx 16..1279); dp_step+init_mode cycles N+1266..N+2289 (idx 0..1023); ready=1 from N+2290.
REQ-030 DP_LAT=1, READY, next at edge M -> dp_step idx 0 in cycle M+1, ks_valid+ready in cycle M+2; DP_LAT=3 -> ks_valid in cycle M+4, ready low M+1..M+3.
REQ-031 1025 back-to-back next pulses -> dp_idx sequence 0..1023 then 0; exactly 1025 ks_valid strobes.
REQ-032 init and next same cycle in READY -> dp_load next cycle, no dp_step, no ks_valid; full setup repeats (2289 cycles).
REQ-033 reset asserted cycle 500 of MIX -> all outputs 0 next cycle; subsequent next ignored until new init completes.
REQ-034 next during EXPAND, init during WAIT -> no effect; sequence timing identical to undisturbed run.
